mul_div_sequencer: RTL and testbench
====================================

// Module: mul_div_sequencer
// PURPOSE
//   Multi-cycle MULT/MULTU/DIV/DIVU engine for the pipelined MIPS core, beside the ALU in EX.
//   It accepts one operation at a time from EX and runs shift-add multiply or restoring divide
//   over WIDTH iterations. It writes the HI/LO register pair and stalls the pipeline while busy.
// PARAMETERS
//   WIDTH   32   operand / HI / LO width (must be >= 4, even)
// PORTS
//   clk        in   1      rising-edge clock
//   rst_n      in   1      asynchronous reset, active low
//   start      in   1      EX issues an op this cycle (sampled only in IDLE)
//   op         in   2      00 MULTU, 01 MULT, 10 DIVU, 11 DIV
//   srcA       in   WIDTH  multiplicand / dividend
//   srcB       in   WIDTH  multiplier / divisor
//   flush      in   1      pipeline flush: abort op in flight
//   busy       out  1      op in flight (state != IDLE)
//   stall      out  1      busy | (start & state==IDLE); holds IF/ID/EX
//   done       out  1      one-cycle pulse: hi/lo just updated
//   divByZero  out  1      qualifies done: divisor was zero
//   hi         out  WIDTH  HI register (product upper / remainder)
//   lo         out  WIDTH  LO register (product lower / quotient)
// BEHAVIOUR
//   Reset (rst_n=0, async): state=IDLE, counter=0; busy, done, divByZero=0; hi=lo=0.
//   FSM: IDLE -> RUN -> FIX -> DONE -> IDLE.
//   - IDLE: if start, latch op, |srcA|, |srcB| and sign bits (signed ops only), counter=0.
//     Next state is RUN, or FIX if op is a divide and srcB==0.
//   - RUN: one iteration per cycle, counter 0..WIDTH-1; after iteration WIDTH-1 -> FIX.
//       multiply: 2*WIDTH-bit accumulator; add multiplicand if LSB, shift right.
//       divide: restoring; shift {rem,quo} left, trial subtract divisor, keep if non-negative.
//   - FIX: sign correction on the unsigned result.
//       MULT: negate the 2*WIDTH product if signs differ.
//       DIV: negate quotient if signs differ; remainder takes the dividend's sign.
//       hi/lo load at the FIX->DONE edge.
//   - DONE: done=1 for exactly this cycle; -> IDLE.
//   Latency: start in cycle 0 -> done in cycle WIDTH+2 (34 at default); busy in cycles 1..WIDTH+2.
//   Divide by zero: IDLE->FIX->DONE, done in cycle 2 with divByZero=1;
//     lo={WIDTH{1'b1}}, hi=srcA unmodified; divByZero is 0 on every other done.
//   DIV of most-negative by -1: lo=most-negative, hi=0, no flag.
//   start while busy: ignored; the op in flight is unaffected.
//   flush in RUN/FIX: -> IDLE next cycle; hi/lo unchanged; no done.
//   flush in DONE: ignored, result commits.
//   flush and start together in IDLE: flush wins, no op is accepted.
//   hi/lo change only at the FIX->DONE edge; they hold between ops.
//   Unsigned ops ignore operand MSB sign. All arithmetic is modulo 2^WIDTH per register.
//   stall is combinational from start/state; all other outputs are registered.
// TESTING
//   1 MULTU FFFFFFFF*FFFFFFFF -> done at cycle 34, hi=FFFFFFFE, lo=00000001.
//   2 MULT FFFFFFFD(-3)*00000005 -> hi=FFFFFFFF, lo=FFFFFFF1; DIV FFFFFFF9(-7)/2 -> lo=FFFFFFFD, hi=FFFFFFFF.
//   3 DIVU 0000000A/0 -> done at cycle 2, divByZero=1, lo=FFFFFFFF, hi=0000000A.
//   4 DIV 80000000/FFFFFFFF -> lo=80000000, hi=0, divByZero=0.
//   5 second start at cycle 5 of a MULTU -> ignored, single done at 34;
//     flush at cycle 10 of a new op -> busy=0 at 11, no done, hi/lo keep prior value.
//   6 rst_n low mid-RUN -> busy, done, hi, lo = 0 immediately; after release, start runs a normal op.

Source files
------------

// File: rtl/mul_div_sequencer_if.sv
// EX <-> multiply/divide sequencer handshake: op issue, flush, stall/busy and HI/LO results.
interface mul_div_sequencer_if #(
  parameter int unsigned WIDTH = 32
);
  logic             start;
  logic [1:0]       op;
  logic [WIDTH-1:0] srcA;
  logic [WIDTH-1:0] srcB;
  logic             flush;
  logic             busy;
  logic             stall;
  logic             done;
  logic             divByZero;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (
    output start, op, srcA, srcB, flush,
    input  busy, stall, done, divByZero, hi, lo
  );

  modport slave (
    input  start, op, srcA, srcB, flush,
    output busy, stall, done, divByZero, hi, lo
  );
endinterface

// File: rtl/mul_div_sequencer.sv
// Multi-cycle MULT/MULTU/DIV/DIVU engine: shift-add multiply and restoring divide on magnitudes,
// sign fix-up in a final cycle, then HI/LO commit with a one-cycle done pulse.
module mul_div_sequencer #(
  parameter int unsigned WIDTH = 32
) (
  input logic               clk,
  input logic               rst_n,
  mul_div_sequencer_if.slave bus
);
  localparam int unsigned CntW = $clog2(WIDTH);

  typedef enum logic [1:0] {StIdle, StRun, StFix, StDone} state_e;

  state_e               state_q, state_d;
  logic [CntW-1:0]      cnt_q, cnt_d;
  logic [2*WIDTH-1:0]   acc_q, acc_d;
  logic [WIDTH-1:0]     a_q, a_d, b_q, b_d;
  logic [1:0]           op_q, op_d;
  logic                 sa_q, sa_d, sb_q, sb_d, dz_q, dz_d, dbz_q, dbz_d;
  logic [WIDTH-1:0]     hi_q, hi_d, lo_q, lo_d;

  logic [WIDTH-1:0]     abs_a, abs_b;
  logic [WIDTH:0]       mul_sum, div_sh, div_diff;
  logic [2*WIDTH-1:0]   prod_neg;
  logic [WIDTH-1:0]     quo_neg, rem_neg;

  assign abs_a = (bus.op[0] && bus.srcA[WIDTH-1]) ? -bus.srcA : bus.srcA;
  assign abs_b = (bus.op[0] && bus.srcB[WIDTH-1]) ? -bus.srcB : bus.srcB;

  // acc holds {product_hi, multiplier} for multiply and {remainder, quotient} for divide
  assign mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, a_q};
  assign div_sh   = acc_q[2*WIDTH-1:WIDTH-1];
  assign div_diff = div_sh - {1'b0, b_q};
  assign prod_neg = -acc_q;
  assign quo_neg  = -acc_q[WIDTH-1:0];
  assign rem_neg  = -acc_q[2*WIDTH-1:WIDTH];

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    a_d     = a_q;
    b_d     = b_q;
    op_d    = op_q;
    sa_d    = sa_q;
    sb_d    = sb_q;
    dz_d    = dz_q;
    dbz_d   = dbz_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    unique case (state_q)
      StIdle: begin
        if (bus.start && !bus.flush) begin
          op_d  = bus.op;
          sa_d  = bus.op[0] & bus.srcA[WIDTH-1];
          sb_d  = bus.op[0] & bus.srcB[WIDTH-1];
          cnt_d = '0;
          b_d   = abs_b;
          dz_d  = bus.op[1] && (bus.srcB == '0);
          // divide-by-zero returns the raw dividend in HI
          a_d   = dz_d ? bus.srcA : abs_a;
          acc_d = bus.op[1] ? {{WIDTH{1'b0}}, abs_a} : {{WIDTH{1'b0}}, abs_b};
          state_d = dz_d ? StFix : StRun;
        end
      end
      StRun: begin
        if (bus.flush) begin
          state_d = StIdle;
        end else begin
          if (!op_q[1]) begin
            acc_d = acc_q[0] ? {mul_sum, acc_q[WIDTH-1:1]} : {1'b0, acc_q[2*WIDTH-1:1]};
          end else if (div_diff[WIDTH]) begin
            acc_d = {div_sh[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
          end else begin
            acc_d = {div_diff[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
          end
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == CntW'(WIDTH - 1)) state_d = StFix;
        end
      end
      StFix: begin
        if (bus.flush) begin
          state_d = StIdle;
        end else begin
          state_d = StDone;
          dbz_d   = dz_q;
          if (dz_q) begin
            hi_d = a_q;
            lo_d = '1;
          end else if (!op_q[1]) begin
            {hi_d, lo_d} = (sa_q ^ sb_q) ? prod_neg : acc_q;
          end else begin
            lo_d = (sa_q ^ sb_q) ? quo_neg : acc_q[WIDTH-1:0];
            hi_d = sa_q ? rem_neg : acc_q[2*WIDTH-1:WIDTH];
          end
        end
      end
      StDone: begin
        state_d = StIdle;
        dbz_d   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      acc_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      op_q    <= '0;
      sa_q    <= 1'b0;
      sb_q    <= 1'b0;
      dz_q    <= 1'b0;
      dbz_q   <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      a_q     <= a_d;
      b_q     <= b_d;
      op_q    <= op_d;
      sa_q    <= sa_d;
      sb_q    <= sb_d;
      dz_q    <= dz_d;
      dbz_q   <= dbz_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

  assign bus.busy      = (state_q != StIdle);
  assign bus.stall     = (state_q != StIdle) | (bus.start & (state_q == StIdle));
  assign bus.done      = (state_q == StDone);
  assign bus.divByZero = dbz_q;
  assign bus.hi        = hi_q;
  assign bus.lo        = lo_q;
endmodule

// File: tb/tb_mul_div_sequencer.sv
// Directed bench for mul_div_sequencer: an arithmetic reference model checked every cycle,
// plus literal expectations for the documented corner cases.
module tb_mul_div_sequencer;
  logic clk = 1'b0;
  logic rst_n = 1'b0;

  mul_div_sequencer_if #(.WIDTH(32)) bus ();

  mul_div_sequencer #(.WIDTH(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int nvec = 0;
  int nerr = 0;
  int cyc = 0;

  // model of what the outputs must be, in terms of cycle numbers
  int busy_from = 0;
  int busy_to = -1;
  int done_at = -1;
  int issue_cyc = 0;
  logic [31:0] exp_hi = '0, exp_lo = '0, pend_hi = '0, pend_lo = '0;
  bit pend_dbz = 1'b0;

  always @(posedge clk) cyc++;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic void model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                                output logic [31:0] h, output logic [31:0] l, output bit z);
    logic [63:0] p;
    longint sa, sb, q, r;
    z = 1'b0;
    sa = $signed(a);
    sb = $signed(b);
    case (op)
      2'b00: begin p = {32'b0, a} * {32'b0, b}; h = p[63:32]; l = p[31:0]; end
      2'b01: begin q = sa * sb; h = q[63:32]; l = q[31:0]; end
      default: begin
        if (b == 0) begin
          z = 1'b1; h = a; l = '1;
        end else if (op == 2'b10) begin
          l = a / b; h = a % b;
        end else begin
          q = sa / sb; r = sa % sb; l = q[31:0]; h = r[31:0];
        end
      end
    endcase
  endfunction

  always @(negedge clk) begin
    bit eb;
    if (cyc == done_at) begin
      exp_hi = pend_hi;
      exp_lo = pend_lo;
    end
    eb = (cyc >= busy_from) && (cyc <= busy_to);
    chk("busy", {31'b0, bus.busy}, {31'b0, eb});
    chk("stall", {31'b0, bus.stall}, {31'b0, eb | (bus.start & ~eb)});
    chk("done", {31'b0, bus.done}, {31'b0, cyc == done_at});
    chk("divByZero", {31'b0, bus.divByZero}, {31'b0, (cyc == done_at) & pend_dbz});
    chk("hi", bus.hi, exp_hi);
    chk("lo", bus.lo, exp_lo);
  end

  task automatic begin_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    logic [31:0] h, l;
    bit z;
    @(posedge clk); #1;
    bus.start = 1'b1; bus.op = op; bus.srcA = a; bus.srcB = b;
    model(op, a, b, h, l, z);
    issue_cyc = cyc;
    busy_from = cyc + 1;
    busy_to   = cyc + (z ? 2 : 34);
    done_at   = busy_to;
    pend_hi = h; pend_lo = l; pend_dbz = z;
    @(posedge clk); #1;
    bus.start = 1'b0;
  endtask

  task automatic wait_done(output int lat);
    int n = 0;
    while (!bus.done && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    lat = cyc - issue_cyc;
  endtask

  typedef struct packed { logic [1:0] op; logic [31:0] a; logic [31:0] b; } vec_t;
  vec_t extra [6] = '{
    '{2'b01, 32'hFFFFFFF9, 32'hFFFFFFFB},
    '{2'b01, 32'h80000000, 32'h80000000},
    '{2'b10, 32'hDEADBEEF, 32'h00001234},
    '{2'b11, 32'h00000007, 32'hFFFFFFFE},
    '{2'b11, 32'h00000000, 32'h00000000},
    '{2'b00, 32'h12345678, 32'h9ABCDEF0}
  };

  initial begin
    int lat;
    bus.start = 1'b0; bus.op = '0; bus.srcA = '0; bus.srcB = '0; bus.flush = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset busy", {31'b0, bus.busy}, 32'd0);
    chk("reset hi", bus.hi, 32'd0);
    chk("reset lo", bus.lo, 32'd0);
    rst_n = 1'b1;

    begin_op(2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF);
    wait_done(lat);
    chk("t1 latency", lat, 32'd34);
    chk("t1 hi", bus.hi, 32'hFFFFFFFE);
    chk("t1 lo", bus.lo, 32'h00000001);

    begin_op(2'b01, 32'hFFFFFFFD, 32'h00000005);
    wait_done(lat);
    chk("t2 mult hi", bus.hi, 32'hFFFFFFFF);
    chk("t2 mult lo", bus.lo, 32'hFFFFFFF1);
    begin_op(2'b11, 32'hFFFFFFF9, 32'h00000002);
    wait_done(lat);
    chk("t2 div lo", bus.lo, 32'hFFFFFFFD);
    chk("t2 div hi", bus.hi, 32'hFFFFFFFF);

    begin_op(2'b10, 32'h0000000A, 32'h00000000);
    wait_done(lat);
    chk("t3 latency", lat, 32'd2);
    chk("t3 divByZero", {31'b0, bus.divByZero}, 32'd1);
    chk("t3 lo", bus.lo, 32'hFFFFFFFF);
    chk("t3 hi", bus.hi, 32'h0000000A);

    begin_op(2'b11, 32'h80000000, 32'hFFFFFFFF);
    wait_done(lat);
    chk("t4 lo", bus.lo, 32'h80000000);
    chk("t4 hi", bus.hi, 32'h00000000);
    chk("t4 divByZero", {31'b0, bus.divByZero}, 32'd0);

    foreach (extra[i]) begin
      begin_op(extra[i].op, extra[i].a, extra[i].b);
      wait_done(lat);
    end

    // second start while busy must be ignored
    begin_op(2'b00, 32'd3, 32'd7);
    repeat (4) @(posedge clk);
    #1;
    bus.start = 1'b1; bus.op = 2'b10; bus.srcA = 32'd99; bus.srcB = 32'd0;
    @(posedge clk); #1;
    bus.start = 1'b0;
    wait_done(lat);
    chk("t5 latency", lat, 32'd34);
    chk("t5 lo", bus.lo, 32'd21);
    chk("t5 hi", bus.hi, 32'd0);

    // flush mid-RUN
    begin_op(2'b01, 32'h00001111, 32'h00002222);
    repeat (8) @(posedge clk);
    #1;
    bus.flush = 1'b1;
    busy_to = cyc;
    done_at = -1;
    @(posedge clk); #1;
    bus.flush = 1'b0;
    chk("t5 flush busy", {31'b0, bus.busy}, 32'd0);
    repeat (40) @(posedge clk);
    #1;
    chk("t5 flush lo", bus.lo, 32'd21);
    chk("t5 flush hi", bus.hi, 32'd0);

    // flush and start together in IDLE: nothing accepted
    bus.start = 1'b1; bus.flush = 1'b1; bus.op = 2'b00; bus.srcA = 32'd5; bus.srcB = 32'd5;
    @(posedge clk); #1;
    bus.start = 1'b0; bus.flush = 1'b0;
    chk("flush+start busy", {31'b0, bus.busy}, 32'd0);

    // asynchronous reset mid-RUN
    begin_op(2'b00, 32'h0000FFFF, 32'h0000FFFF);
    repeat (8) @(posedge clk);
    #1;
    rst_n = 1'b0;
    busy_to = -1; done_at = -1; exp_hi = '0; exp_lo = '0;
    #1;
    chk("t6 busy", {31'b0, bus.busy}, 32'd0);
    chk("t6 done", {31'b0, bus.done}, 32'd0);
    chk("t6 hi", bus.hi, 32'd0);
    chk("t6 lo", bus.lo, 32'd0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    begin_op(2'b10, 32'd100, 32'd7);
    wait_done(lat);
    chk("t6 latency", lat, 32'd34);
    chk("t6 lo after", bus.lo, 32'd14);
    chk("t6 hi after", bus.hi, 32'd2);

    repeat (3) @(posedge clk);
    #1;
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
